jk_register_bank: RTL
=====================

Name: jk_register_bank

Overview:
- Parametrised multi-bit JK register bank. Successor to the single-bit JK flip-flop.
- Each of WIDTH bits behaves as an edge-triggered JK flip-flop.
- Adds clock enable, asynchronous reset to a programmable value, a parallel-load mode, and up/down binary counting built from the JK toggle chain.
- Used as a general state/counter element in the behavioural-modelling library.

Parameters:
- WIDTH, 4, number of JK bits (1 to 32).
- RESET_VAL, 0, value loaded into q on reset (WIDTH bits).

Ports:
- clock  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- en  input  1  clock enable; state holds when 0.
- mode  input  2  0=JK, 1=count up, 2=count down, 3=parallel load.
- j  input  WIDTH  per-bit J (mode 0 only).
- k  input  WIDTH  per-bit K (mode 0 only).
- d  input  WIDTH  load data (mode 3 only).
- q  output  WIDTH  registered state.
- q_bar  output  WIDTH  bitwise complement of q, combinational from q.
- wrap  output  1  registered one-cycle pulse on counter wrap.
- changed  output  1  registered one-cycle pulse when q changed value on the last edge.

Behaviour:
- Reset (reset_n=0, asynchronous, no clock needed):
  - q=RESET_VAL, q_bar=~RESET_VAL, wrap=0, changed=0.
  - Outputs hold these values while reset_n is low.
  - Reset takes priority over everything, including mid-count or mid-load.
- Release: first active edge is the first rising clock with reset_n=1.
- All updates occur on the rising clock edge. Latency is one cycle from inputs to q.
- en=0: q holds; wrap=0 and changed=0 on that edge. mode, j, k and d are ignored.
- en=1, mode 0 (JK), per bit i:
  - j=0, k=0: hold.
  - j=0, k=1: q[i]=0.
  - j=1, k=0: q[i]=1.
  - j=1, k=1: q[i] toggles.
  - wrap=0.
- en=1, mode 1 (up):
  - Toggle bit i iff all bits below i are 1 (bit 0 always toggles), i.e. q=q+1 mod 2^WIDTH.
  - wrap=1 on the edge where q goes all-ones to 0.
- en=1, mode 2 (down):
  - Toggle bit i iff all bits below i are 0, i.e. q=q-1 mod 2^WIDTH.
  - wrap=1 on the edge where q goes 0 to all-ones.
- en=1, mode 3 (load): q=d, wrap=0.
- changed=1 on an edge iff new q differs from old q. A load of an equal value gives changed=0.
- Mode changes take effect on the same edge. No internal mode state; the block is stateless beyond q, wrap and changed.
- WIDTH=1: up and down both toggle every enabled edge, and wrap pulses every enabled edge.
- Unknown or X on mode while en=1 is not supported; the bench must not drive it.

Optional Feature:
- Macro: JK_BANK_SYNC_CLR_EN.
- When defined:
  - Extra input port clr (1 bit).
  - clr=1 on a rising edge forces q=RESET_VAL regardless of en and mode.
  - wrap=0 on that edge; changed follows the normal rule.
  - clr is below reset_n in priority.
- When undefined: port clr is absent, and behaviour is exactly as above.

Test Plan:
1. reset_n=0 asynchronously mid-cycle with RESET_VAL=4'b1010 -> q=1010 and q_bar=0101 immediately; wrap=0, changed=0.
2. Mode 0, en=1, q=0000, j=1100, k=1010 -> q=1100 next edge. Then j=k=1111 -> q=0011, changed=1. Then j=k=0000 -> q holds 0011, changed=0.
3. Mode 1, en=1 from q=1110, 3 edges -> q=1111, then 0000 with wrap=1 for exactly one cycle, then 0001.
4. Mode 2 from q=0001, 2 edges -> q=0000, then 1111 with wrap=1 on the second edge. Drop en=0 for 2 cycles -> q holds 1111, wrap=0.
5. Mode 3, d=0110 -> q=0110 and changed=1. Repeat load of 0110 -> changed=0. Assert reset_n=0 during count -> q=RESET_VAL without waiting for a clock edge.
6. With JK_BANK_SYNC_CLR_EN: mode 1 counting at q=0101, clr=1, en=0 -> q=RESET_VAL next edge, wrap=0. Rebuild without the macro and confirm tests 1-5 still pass.

Source files
------------

// File: rtl/jk_register_bank.sv
// jk_register_bank: WIDTH-bit bank of edge-triggered JK flip-flops.
// Besides plain JK operation, the bank can count up or down using the JK toggle
// chain, and it can load a parallel value. It also has a clock enable and an
// asynchronous reset to RESET_VAL.
//
// Ports:
//   clock    rising-edge clock
//   reset_n  asynchronous active-low reset, q <= RESET_VAL
//   en       clock enable; when it is 0, state holds and the pulses are 0
//   mode     0=JK, 1=count up, 2=count down, 3=parallel load
//   j, k     per-bit JK inputs (mode 0)
//   d        load data (mode 3)
//   clr      synchronous clear to RESET_VAL (only with JK_BANK_SYNC_CLR_EN)
//   q        registered state
//   q_bar    ~q
//   wrap     one-cycle pulse when the counter wraps
//   changed  one-cycle pulse when q changed on the last edge
//
// Optional macro: JK_BANK_SYNC_CLR_EN adds the clr input.

// One JK cell. The up/down toggle qualifiers come from the bank-level chain.
module jk_bit (
  input  logic       q,
  input  logic       en,
  input  logic [1:0] mode,
  input  logic       j,
  input  logic       k,
  input  logic       d,
  input  logic       tu,
  input  logic       td,
  output logic       qn
);
  always_comb begin
    qn = q;
    if (en) begin
      case (mode)
        2'd0: begin
          case ({j, k})
            2'b01:   qn = 1'b0;
            2'b10:   qn = 1'b1;
            2'b11:   qn = ~q;
            default: qn = q;
          endcase
        end
        2'd1:    qn = q ^ tu;
        2'd2:    qn = q ^ td;
        default: qn = d;
      endcase
    end
  end
endmodule

module jk_register_bank #(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic [WIDTH-1:0] d,
`ifdef JK_BANK_SYNC_CLR_EN
  input  logic             clr,
`endif
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar,
  output logic             wrap,
  output logic             changed
);
  logic [WIDTH-1:0] tu, td, q_cell, q_nxt;
  logic             wrap_cell, wrap_nxt;

  // Toggle chain: in up mode a bit toggles when all lower bits are 1.
  // In down mode it toggles when all lower bits are 0.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    if (i == 0) begin : g_lsb
      assign tu[i] = 1'b1;
      assign td[i] = 1'b1;
    end else begin : g_up
      assign tu[i] = &q[i-1:0];
      assign td[i] = ~|q[i-1:0];
    end
    jk_bit u_bit (
      .q    (q[i]),
      .en   (en),
      .mode (mode),
      .j    (j[i]),
      .k    (k[i]),
      .d    (d[i]),
      .tu   (tu[i]),
      .td   (td[i]),
      .qn   (q_cell[i])
    );
  end

  // For a single bit, every enabled count edge is treated as a wrap.
  always_comb begin
    wrap_cell = 1'b0;
    if (en) begin
      if (WIDTH == 1)
        wrap_cell = (mode == 2'd1) || (mode == 2'd2);
      else
        wrap_cell = ((mode == 2'd1) && (&q)) || ((mode == 2'd2) && (~|q));
    end
  end

`ifdef JK_BANK_SYNC_CLR_EN
  // clr overrides en and mode. It ranks only below the asynchronous reset.
  assign q_nxt    = clr ? RESET_VAL : q_cell;
  assign wrap_nxt = clr ? 1'b0 : wrap_cell;
`else
  assign q_nxt    = q_cell;
  assign wrap_nxt = wrap_cell;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      q       <= RESET_VAL;
      wrap    <= 1'b0;
      changed <= 1'b0;
    end else begin
      q       <= q_nxt;
      wrap    <= wrap_nxt;
      changed <= (q_nxt != q);
    end
  end

  assign q_bar = ~q;
endmodule
